// File: rtl/cm0_core_mul_pkg.sv
// Shared types and constants for the core multiplier sequencer.
// The bit-select index runs 1..31 then 0, so IMM_LAST marks the final iteration.
package cm0_core_mul_pkg;

    localparam int MUL_W = 32;
    localparam int IMM_W = 5;

    localparam logic [IMM_W-1:0] IMM_FIRST = 5'd1;
    localparam logic [IMM_W-1:0] IMM_LAST  = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/cm0_core_mul_acc.sv
// MSB-first shift-and-add accumulator for the small multiplier.
// It holds the captured multiplicand and exposes the next accumulator value for result capture.
module cm0_core_mul_acc
    import cm0_core_mul_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             sel_i,
    input  logic [MUL_W-1:0] opb_i,
    output logic [MUL_W-1:0] acc_nxt_o
);

    logic [MUL_W-1:0] mcand_q;
    logic [MUL_W-1:0] mcand_d;
    logic [MUL_W-1:0] acc_q;
    logic [MUL_W-1:0] acc_d;

    // One iteration: shift in the next lower multiplier bit, discarding the carry out of bit 31.
    assign acc_nxt_o = {acc_q[MUL_W-2:0], 1'b0} + (sel_i ? mcand_q : {MUL_W{1'b0}});

    // Next-state selection for multiplicand and accumulator.
    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        if (clr_i) begin
            acc_d = {MUL_W{1'b0}};
        end else if (load_i) begin
            mcand_d = opb_i;
            acc_d   = {MUL_W{1'b0}};
        end else if (en_i) begin
            acc_d = acc_nxt_o;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator and multiplicand registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q <= {MUL_W{1'b0}};
            acc_q   <= {MUL_W{1'b0}};
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/cm0_core_mul_seq.sv
// Consumer-side sequencer for the core multiplier: start/done handshake towards execute,
// either a single-cycle array capture (SMUL==0) or a 32-step bit-serial MULS (SMUL!=0).
module cm0_core_mul_seq
    import cm0_core_mul_pkg::*;
#(
    parameter int SMUL = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             kill_i,
    input  logic [MUL_W-1:0] opb_i,
    input  logic [MUL_W-1:0] mul_res_i,
    input  logic             mul_sel_i,
    output logic             mul_ctl_o,
    output logic [IMM_W-1:0] imm_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [MUL_W-1:0] res_o
);

    localparam bit SMALL = (SMUL != 0);

    mul_state_e       state_q;
    mul_state_e       state_d;
    logic [IMM_W-1:0] cnt_q;
    logic [IMM_W-1:0] cnt_d;
    logic [MUL_W-1:0] res_q;
    logic [MUL_W-1:0] res_d;
    logic [MUL_W-1:0] acc_nxt_s;
    logic             accept_s;
    logic             run_s;

    assign accept_s = start_i & (state_q == ST_IDLE) & ~kill_i;
    assign run_s    = (state_q == ST_RUN);

    generate
        if (SMALL) begin : gen_small
            logic unused_small_s;
            assign unused_small_s = ^mul_res_i;

            cm0_core_mul_acc u_acc (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .load_i    (accept_s),
                .clr_i     (kill_i),
                .en_i      (run_s),
                .sel_i     (mul_sel_i),
                .opb_i     (opb_i),
                .acc_nxt_o (acc_nxt_s)
            );
        end else begin : gen_fast
            logic unused_fast_s;
            assign unused_fast_s = ^{opb_i, mul_sel_i};
            assign acc_nxt_s     = {MUL_W{1'b0}};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; kill overrides everything and returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (kill_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_d = SMALL ? ST_RUN : ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == IMM_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Counter and result next values; res_q only moves when a result completes.
    always_comb begin
        cnt_d = cnt_q;
        res_d = res_q;
        if (kill_i) begin
            cnt_d = {IMM_W{1'b0}};
        end else if (accept_s) begin
            if (SMALL) begin
                cnt_d = IMM_FIRST;
            end else begin
                res_d = mul_res_i;
            end
        end else if (run_s) begin
            if (cnt_q == IMM_LAST) begin
                cnt_d = {IMM_W{1'b0}};
                res_d = acc_nxt_s;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {IMM_W{1'b0}};
            res_q <= {MUL_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
            res_q <= res_d;
        end
    end

    // Output decode.
    always_comb begin
        mul_ctl_o = 1'b0;
        imm_o     = {IMM_W{1'b0}};
        if (!SMALL) begin
            mul_ctl_o = accept_s;
        end else begin
            mul_ctl_o = 1'b0;
        end
        if (run_s) begin
            imm_o = cnt_q;
        end else begin
            imm_o = {IMM_W{1'b0}};
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);
    assign res_o  = res_q;

endmodule

// File: tb/tb_cm0_core_mul_seq.sv
// Directed bench for both multiplier configurations with an expected-result scoreboard.
module tb_cm0_core_mul_seq;

    logic        clk;
    logic        rst;

    logic        start_s, kill_s, sel_s, mctl_s, busy_s, done_s;
    logic [4:0]  imm_s;
    logic [31:0] opb_s, res_s, mres_s;

    logic        start_f, kill_f, mctl_f, busy_f, done_f;
    logic [4:0]  imm_f;
    logic [31:0] res_f, mres_f;

    logic [31:0] ra_v;
    logic [4:0]  sel_idx;
    logic [31:0] sb[$];
    logic [31:0] last_res;
    int          n_cmp;
    int          n_fail;

    cm0_core_mul_seq #(.SMUL(1)) dut_s (
        .clk_i(clk), .rst_i(rst), .start_i(start_s), .kill_i(kill_s), .opb_i(opb_s),
        .mul_res_i(mres_s), .mul_sel_i(sel_s), .mul_ctl_o(mctl_s), .imm_o(imm_s),
        .busy_o(busy_s), .done_o(done_s), .res_o(res_s)
    );

    cm0_core_mul_seq #(.SMUL(0)) dut_f (
        .clk_i(clk), .rst_i(rst), .start_i(start_f), .kill_i(kill_f), .opb_i(opb_s),
        .mul_res_i(mres_f), .mul_sel_i(1'b0), .mul_ctl_o(mctl_f), .imm_o(imm_f),
        .busy_o(busy_f), .done_o(done_f), .res_o(res_f)
    );

    // Array model: index k selects Ra bit (32-k) mod 32.
    assign sel_idx = 5'd0 - imm_s;
    assign sel_s   = ra_v[sel_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            last_res = e;
            check(tag, obs, e);
        end
    endtask

    // Small-mode operation; kill_at!=0 aborts in that RUN cycle, pmask re-pulses start with junk opb.
    task automatic small_op(input logic [31:0] ra, input logic [31:0] opb, input logic [31:0] exp,
                            input int kill_at, input logic [33:0] pmask, input string tag);
        int imm_err = 0;
        int bsy_err = 0;
        int late_done = 0;
        @(posedge clk); #1;
        ra_v = ra; opb_s = opb; start_s = 1'b1;
        if (kill_at == 0) sb.push_back(exp);
        @(negedge clk);
        check({tag, "_idle_busy"}, {31'd0, busy_s}, 32'd0);
        check({tag, "_mctl"}, {31'd0, mctl_s}, 32'd0);
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk); #1;
            start_s = pmask[k];
            opb_s   = pmask[k] ? 32'hDEAD_BEEF : opb;
            kill_s  = (k == kill_at);
            @(negedge clk);
            if (kill_at != 0 && k == kill_at + 1) begin
                check({tag, "_kill_busy"}, {31'd0, busy_s}, 32'd0);
                check({tag, "_kill_imm"}, {27'd0, imm_s}, 32'd0);
                check({tag, "_kill_done"}, {31'd0, done_s}, 32'd0);
                check({tag, "_kill_res"}, res_s, last_res);
                break;
            end
            if (k <= 32) begin
                if (imm_s !== 5'(k)) imm_err++;
                if (busy_s !== 1'b1 || done_s !== 1'b0) bsy_err++;
            end else begin
                check({tag, "_done"}, {31'd0, done_s}, 32'd1);
                check({tag, "_done_busy"}, {31'd0, busy_s}, 32'd1);
                check({tag, "_done_imm"}, {27'd0, imm_s}, 32'd0);
                pop_check({tag, "_res"}, res_s);
            end
        end
        start_s = 1'b0; kill_s = 1'b0; opb_s = opb;
        check({tag, "_imm_seq_errs"}, imm_err, 32'd0);
        check({tag, "_busy_seq_errs"}, bsy_err, 32'd0);
        if (kill_at != 0) begin
            for (int j = 0; j < 36; j++) begin
                @(negedge clk);
                if (done_s !== 1'b0) late_done++;
            end
            check({tag, "_no_done_after_kill"}, late_done, 32'd0);
        end
    endtask

    initial begin
        logic [33:0] pm;
        n_cmp = 0; n_fail = 0; last_res = 32'd0;
        rst = 1'b1; start_s = 1'b0; kill_s = 1'b0; opb_s = 32'd0; mres_s = 32'd0; ra_v = 32'd0;
        start_f = 1'b0; kill_f = 1'b0; mres_f = 32'd0;
        #12;
        check("rst_busy_s", {31'd0, busy_s}, 32'd0);
        check("rst_done_s", {31'd0, done_s}, 32'd0);
        check("rst_imm_s", {27'd0, imm_s}, 32'd0);
        check("rst_res_s", res_s, 32'd0);
        check("rst_busy_f", {31'd0, busy_f}, 32'd0);
        check("rst_res_f", res_f, 32'd0);
        @(negedge clk); rst = 1'b0;

        small_op(32'd7, 32'd6, 32'h0000_002A, 0, 34'd0, "t1_7x6");
        small_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 34'd0, "t2_ffxff");
        small_op(32'h8000_0000, 32'h0000_0003, 32'h8000_0000, 0, 34'd0, "t2_trunc");
        small_op(32'd3, 32'd99, 32'd0, 10, 34'd0, "t3_kill");
        small_op(32'd3, 32'd5, 32'h0000_000F, 0, 34'd0, "t3_3x5");

        pm = 34'd0; pm[5] = 1'b1; pm[32] = 1'b1; pm[33] = 1'b1;
        small_op(32'd9, 32'h11, 32'h0000_0099, 0, pm, "t4_ignore");
        small_op(32'd4, 32'h100, 32'h0000_0400, 0, 34'd0, "t4_next");

        // Fast mode: single-cycle capture.
        @(posedge clk); #1;
        start_f = 1'b1; mres_f = 32'h1234_5678; sb.push_back(32'h1234_5678);
        @(negedge clk);
        check("t5_mctl_start", {31'd0, mctl_f}, 32'd1);
        check("t5_busy_start", {31'd0, busy_f}, 32'd0);
        @(posedge clk); #1;
        start_f = 1'b0; mres_f = 32'hAAAA_5555;
        @(negedge clk);
        check("t5_mctl_done", {31'd0, mctl_f}, 32'd0);
        check("t5_done", {31'd0, done_f}, 32'd1);
        check("t5_busy_done", {31'd0, busy_f}, 32'd1);
        check("t5_imm", {27'd0, imm_f}, 32'd0);
        pop_check("t5_res", res_f);
        @(posedge clk); #1;
        start_f = 1'b1; kill_f = 1'b1;
        @(negedge clk);
        check("t5_prev_done_clear", {31'd0, done_f}, 32'd0);
        check("t5_kill_mctl", {31'd0, mctl_f}, 32'd0);
        @(posedge clk); #1;
        start_f = 1'b0; kill_f = 1'b0;
        @(negedge clk);
        check("t5_kill_done", {31'd0, done_f}, 32'd0);
        check("t5_kill_busy", {31'd0, busy_f}, 32'd0);
        check("t5_kill_res", res_f, 32'h1234_5678);

        // Asynchronous reset in the middle of a small-mode run.
        @(posedge clk); #1;
        ra_v = 32'd2; opb_s = 32'd3; start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("t6_busy_pre", {31'd0, busy_s}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_busy", {31'd0, busy_s}, 32'd0);
        check("t6_rst_done", {31'd0, done_s}, 32'd0);
        check("t6_rst_imm", {27'd0, imm_s}, 32'd0);
        check("t6_rst_res", res_s, 32'd0);
        check("t6_rst_mctl", {31'd0, mctl_s}, 32'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        last_res = 32'd0;
        small_op(32'd2, 32'd2, 32'h0000_0004, 0, 34'd0, "t6_2x2");

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
